uart_boot_loader: RTL
=====================

Name: uart_boot_loader

Overview:
- Sits upstream of the multicycle core and its unified instruction/data RAM.
- Consumes the byte stream from uart_rx and assembles big-endian 32-bit words.
- Writes the words into the RAM from word address 0, returns a one-byte acknowledge through uart_tx, then releases the core's reset.
- The core runs only after a complete, valid program image has been loaded.

Parameters:
- ADDR_W, 15: width of the RAM word address; the maximum image is 2^ADDR_W words.
- ACK_BYTE, 8'hAA: byte sent on successful load.
- NAK_BYTE, 8'hEE: byte sent on load failure.

Ports:
- clk  in  1  system clock
- rstn  in  1  synchronous active-low reset
- rx_data  in  8  received byte from uart_rx, valid with rx_ready
- rx_ready  in  1  one-cycle pulse, new byte available
- rx_ferr  in  1  framing error from uart_rx, sampled with rx_ready
- tx_busy  in  1  uart_tx busy
- tx_data  out  8  byte to send
- tx_start  out  1  one-cycle pulse to uart_tx
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM word address
- mem_wdata  out  32  RAM write data
- cpu_rstn  out  1  active-low reset to the core; 0 while loading
- done  out  1  load complete, core running
- err  out  1  sticky load failure

Behaviour:
- Reset is synchronous, active-low on rstn, clock clk.
- Reset values: tx_start=0, tx_data=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rstn=0, done=0, err=0. Byte counter, word counter and length register are cleared; state is LEN.
- Reset mid-load aborts the load and restarts at LEN. Partially written RAM contents are left as they are.
- Byte assembly: the first byte of each group lands in [31:24], the last in [7:0]. A 2-bit byte index wraps 3->0.
- Any rx_ready with rx_ferr=1 in LEN or DATA goes to NAK.
- States:
  - LEN: collect 4 bytes into len (word count).
    - len==0 -> ACK.
    - len > 2^ADDR_W -> NAK.
    - Otherwise -> DATA.
  - DATA: on the 4th byte of a word, the next cycle drives mem_we=1 for exactly one cycle, with mem_wdata = assembled word and mem_addr = word count.
    - Word count increments after the write.
    - After the write of word len-1 -> ACK (or CSUM when the option is compiled in).
  - ACK: wait for tx_busy==0, drive tx_data=ACK_BYTE and pulse tx_start for one cycle -> RUN.
  - NAK: wait for tx_busy==0, drive tx_data=NAK_BYTE and pulse tx_start for one cycle -> ERR.
  - RUN: cpu_rstn=1 and done=1 from the cycle after the tx_start pulse. All rx_ready is ignored. Only rstn leaves this state.
  - ERR: err=1, cpu_rstn stays 0. rx is ignored; only rstn leaves this state.
- Boundaries:
  - The final word address is len-1; mem_addr never wraps because len is bounded.
  - An rx_ready arriving in the same cycle as mem_we is accepted as byte 0 of the next word, so no byte is lost.
  - tx_start is never asserted while tx_busy=1.

Optional Feature:
- Macro: UART_BOOT_CHECKSUM_EN.
- Defined:
  - An 8-bit running sum (mod 256) covers every byte received in DATA.
  - After the last word, state CSUM accepts one more byte.
  - Byte equal to the sum -> ACK; mismatch or framing error -> NAK.
  - A len==0 image still expects the checksum byte, value 0.
- Undefined: no CSUM state and no sum logic; DATA goes directly to ACK.

Decomposition:
- Shared package (boot_pkg) holds:
  - the state enum: LEN, DATA, CSUM, ACK, NAK, RUN, ERR;
  - ACK_BYTE and NAK_BYTE defaults;
  - the byte-index width.
- One natural sub-module: word_assembler (shift-in of 4 bytes, emits a word_valid pulse and the word). The top keeps the FSM, counters and the tx handshake.

Test Plan:
- Send len=00 00 00 02, then words 20 08 00 05 and AC 00 00 00 -> mem_we pulses twice: addr 0 with 0x20080005, addr 1 with 0xAC000000. Then tx_data=0xAA with a single tx_start, then cpu_rstn=1 and done=1.
- len=0 -> no mem_we, ACK sent, done=1.
- Set rx_ferr=1 on the 2nd data byte -> no further mem_we, 0xEE sent, err=1, cpu_rstn stays 0.
- len=2^ADDR_W+1 -> NAK, no mem_we.
- Hold tx_busy=1 for 100 cycles at ACK -> tx_start is delayed until tx_busy falls, and done stays 0 until then.
- Assert rstn=0 after 5 data bytes, then replay a full image -> RAM writes restart at addr 0 and the image loads correctly. With UART_BOOT_CHECKSUM_EN defined, a wrong checksum byte -> 0xEE and err=1.

Source files
------------

// File: rtl/boot_pkg.sv
// Shared types and defaults for the UART boot loader: state encoding,
// acknowledge byte values and the byte-index width used by word assembly.
package boot_pkg;

    typedef enum logic [2:0] {
        ST_LEN,
        ST_DATA,
        ST_CSUM,
        ST_ACK,
        ST_NAK,
        ST_RUN,
        ST_ERR
    } boot_state_t;

    localparam logic [7:0]  ACK_BYTE_DEF = 8'hAA;
    localparam logic [7:0]  NAK_BYTE_DEF = 8'hEE;
    localparam int unsigned BIDX_W       = 2;

endpackage

// File: rtl/word_assembler.sv
// Shifts received bytes into big-endian 32-bit words; o_word_valid pulses
// for one cycle, the cycle after the fourth byte of a group.
module word_assembler
    import boot_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_valid,
    input  logic [7:0]  i_byte,
    output logic        o_word_valid,
    output logic [31:0] o_word
);

    logic [BIDX_W-1:0] r_idx;
    logic [23:0]       r_shift;
    logic [31:0]       r_word;
    logic              r_valid;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_idx   <= '0;
            r_shift <= '0;
            r_word  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (i_valid) begin
                r_shift <= {r_shift[15:0], i_byte};
                r_idx   <= r_idx + 1'b1;
                if (r_idx == '1) begin
                    r_word  <= {r_shift, i_byte};
                    r_valid <= 1'b1;
                end
            end
        end
    end

    assign o_word_valid = r_valid;
    assign o_word       = r_word;

endmodule

// File: rtl/uart_boot_loader.sv
// Loads a length-prefixed big-endian word image from UART into RAM, answers
// ACK/NAK and then releases the core. Optional trailing checksum byte is
// compiled in with `define UART_BOOT_CHECKSUM_EN.
module uart_boot_loader
    import boot_pkg::*;
#(
    parameter int unsigned ADDR_W   = 15,
    parameter logic [7:0]  ACK_BYTE = ACK_BYTE_DEF,
    parameter logic [7:0]  NAK_BYTE = NAK_BYTE_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [7:0]        rx_data,
    input  logic              rx_ready,
    input  logic              rx_ferr,
    input  logic              tx_busy,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_rstn,
    output logic              done,
    output logic              err
);

    localparam logic [31:0] LEN_MAX = 32'd1 << ADDR_W;

`ifdef UART_BOOT_CHECKSUM_EN
    localparam boot_state_t ST_IMG_END = ST_CSUM;
`else
    localparam boot_state_t ST_IMG_END = ST_ACK;
`endif

    boot_state_t       r_state;
    boot_state_t       w_state_nxt;
    logic [31:0]       r_len;
    logic [ADDR_W-1:0] r_wcnt;
    logic              w_asm_valid;
    logic              w_word_valid;
    logic [31:0]       w_word;
    logic              w_mem_we;
    logic              w_last_word;
    logic              w_rx_bad;

    // A byte landing in the write cycle is still shifted in, so it becomes byte 0 of the next word.
    assign w_asm_valid = rx_ready && !rx_ferr && (r_state == ST_LEN || r_state == ST_DATA);
    assign w_rx_bad    = rx_ready && rx_ferr;

    word_assembler u_asm (
        .clk          (clk),
        .rstn         (rstn),
        .i_valid      (w_asm_valid),
        .i_byte       (rx_data),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    assign w_mem_we    = (r_state == ST_DATA) && w_word_valid;
    assign w_last_word = (32'(r_wcnt) == r_len - 32'd1);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_len  <= '0;
            r_wcnt <= '0;
        end else begin
            if (r_state == ST_LEN && w_word_valid) begin
                r_len <= w_word;
            end
            if (w_mem_we) begin
                r_wcnt <= r_wcnt + 1'b1;
            end
        end
    end

`ifdef UART_BOOT_CHECKSUM_EN
    logic [7:0] r_sum;

    // Summed per written word so bytes accepted across the LEN->DATA edge are covered.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_sum <= '0;
        end else if (w_mem_we) begin
            r_sum <= r_sum + w_word[31:24] + w_word[23:16] + w_word[15:8] + w_word[7:0];
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= ST_LEN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        tx_start    = 1'b0;
        tx_data     = '0;
        case (r_state)
            ST_LEN: begin
                if (w_rx_bad) begin
                    w_state_nxt = ST_NAK;
                end else if (w_word_valid) begin
                    if (w_word == 32'd0) begin
                        w_state_nxt = ST_IMG_END;
                    end else if (w_word > LEN_MAX) begin
                        w_state_nxt = ST_NAK;
                    end else begin
                        w_state_nxt = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (w_rx_bad) begin
                    w_state_nxt = ST_NAK;
                end else if (w_mem_we && w_last_word) begin
                    w_state_nxt = ST_IMG_END;
                end
            end
`ifdef UART_BOOT_CHECKSUM_EN
            ST_CSUM: begin
                if (rx_ready) begin
                    w_state_nxt = (!rx_ferr && rx_data == r_sum) ? ST_ACK : ST_NAK;
                end
            end
`endif
            ST_ACK: begin
                tx_data = ACK_BYTE;
                if (!tx_busy) begin
                    tx_start    = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_NAK: begin
                tx_data = NAK_BYTE;
                if (!tx_busy) begin
                    tx_start    = 1'b1;
                    w_state_nxt = ST_ERR;
                end
            end
            ST_RUN:  w_state_nxt = ST_RUN;
            ST_ERR:  w_state_nxt = ST_ERR;
            default: w_state_nxt = ST_LEN;
        endcase
    end

    assign mem_we    = w_mem_we;
    assign mem_addr  = r_wcnt;
    assign mem_wdata = w_word;
    assign cpu_rstn  = (r_state == ST_RUN);
    assign done      = (r_state == ST_RUN);
    assign err       = (r_state == ST_ERR);

endmodule
